// File: rtl/noc_out_pkg.sv
// noc_out_pkg: register map and bit positions shared by the NoC 8-bit output port.
package noc_out_pkg;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL     = 4;
  localparam int CTL_FLUSH  = 0;
  localparam int CTL_IRQ_EN = 1;
endpackage

// File: rtl/noc_out_sync_fifo.sv
// noc_out_sync_fifo: synchronous FIFO with flush; head reads 0 when empty.
module noc_out_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic push_ok, pop_ok;
  assign full_o  = lvl_q == LVL_W'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  always_comb begin
    rd_d  = flush_i ? '0 : pop_ok ? rd_q + AW'(1) : rd_q;
    wr_d  = flush_i ? '0 : push_ok ? wr_q + AW'(1) : wr_q;
    lvl_d = flush_i ? '0 :
            (push_ok && !pop_ok) ? lvl_q + LVL_W'(1) :
            (!push_ok && pop_ok) ? lvl_q - LVL_W'(1) : lvl_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
    end
  end
  // Storage needs no reset: head is masked to 0 while the level is 0.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/nios_noc_8_out_fifo.sv
// nios_noc_8_out_fifo: Avalon-MM slave feeding bytes from a FIFO onto the 8-bit NoC link.
// Optional interrupt on empty enabled by defining NOC_OUT_IRQ_EN.
module nios_noc_8_out_fifo
  import noc_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        out_valid,
  input  logic        out_ready
`ifdef NOC_OUT_IRQ_EN
  ,
  output logic        irq
`endif
);
  logic wr, push_req, ctl_wr, flush, pop, full, empty;
  logic ovf_q, ovf_d, irq_en_q;
  logic [LVL_W-1:0] level;
  logic [31:0] rd_q, rd_d, status, control;
  logic unused_bits;
  assign wr       = chipselect && !write_n;
  assign push_req = wr && address == REG_DATA;
  assign ctl_wr   = wr && address == REG_CONTROL;
  assign flush    = ctl_wr && writedata[CTL_FLUSH];
  assign pop      = out_valid && out_ready;
  assign out_valid = !empty;
  assign readdata  = rd_q;
  assign unused_bits = ^{writedata[31:8], writedata[CTL_IRQ_EN]};
  noc_out_sync_fifo #(.W(8), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_req),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (writedata[7:0]),
    .head_o  (out_port),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf_q;
    status[ST_LVL +: LVL_W] = level;
    control = '0;
    control[CTL_IRQ_EN] = irq_en_q;
    rd_d  = address == REG_STATUS ? status : address == REG_CONTROL ? control : '0;
    ovf_d = flush ? 1'b0 : (push_req && full) ? 1'b1 : ovf_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef NOC_OUT_IRQ_EN
  logic irq_q;
  assign irq = irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= ctl_wr ? writedata[CTL_IRQ_EN] : irq_en_q;
      irq_q    <= irq_en_q && empty;
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif
endmodule
